noc_packet_injector: RTL and testbench

- Local-side network interface that sits directly upstream of a router local input port; its sender_* outputs drive the router's Noc_x_y_receive_* inputs.
- Accepts a packet request (destination coordinates plus payload length), then a stream of payload words.
- Emits one header flit followed by body flits, with header/tail markers, under valid/ready flow control.
- Replaces the hand-written traffic logic in test nodes and serves as the production packetizer for compute tiles.

---
 rtl/noc_packet_injector.sv | 155 +++++++++++++++
 tb/tb_noc_packet_injector.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_packet_injector.sv
// Local-side packetizer: turns a (dest, len) request plus a payload stream into
// header + body flits for a router local input port, behind a one-entry output register.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a packet request; req_ready=1
// HEAD  | request latched; header is loaded as soon as the slot frees
// BODY  | forwarding payload words; pl_ready follows the output slot
module noc_packet_injector #(
    parameter int DATA_W  = 32,
    parameter int COORD_W = 4,
    parameter int X_ID    = 0,
    parameter int Y_ID    = 0
) (
    input  logic               noc_clk,
    input  logic               noc_rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COORD_W-1:0] req_dest_x,
    input  logic [COORD_W-1:0] req_dest_y,
    input  logic [7:0]         req_len,
    input  logic               pl_valid,
    output logic               pl_ready,
    input  logic [DATA_W-1:0]  pl_data,
    output logic               sender_valid,
    input  logic               sender_ready,
    output logic [DATA_W-1:0]  sender_flit,
    output logic               sender_is_header,
    output logic               sender_is_tail,
    output logic [7:0]         sent_pkt_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

    localparam logic [COORD_W-1:0] SRC_X = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] SRC_Y = COORD_W'(Y_ID);

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [7:0]         remaining;
    logic [7:0]         remaining_nxt;
    logic [COORD_W-1:0] dest_x_q;
    logic [COORD_W-1:0] dest_y_q;
    logic [7:0]         len_q;
    logic [DATA_W-1:0]  header_flit;

    logic slot_free;
    logic req_hs;
    logic load_hdr;
    logic load_body;
    logic tail_hs;

    assign slot_free = !sender_valid || sender_ready;
    assign req_ready = (state == ST_IDLE);
    assign pl_ready  = (state == ST_BODY) && slot_free;
    assign req_hs    = req_valid && req_ready;
    assign load_hdr  = (state == ST_HEAD) && slot_free;
    assign load_body = pl_valid && pl_ready;
    assign tail_hs   = sender_valid && sender_ready && sender_is_tail;

    // Built field by field so a DATA_W with no padding gap still elaborates.
    always_comb begin
        header_flit = '0;
        header_flit[DATA_W-1 -: COORD_W]           = dest_x_q;
        header_flit[DATA_W-COORD_W-1 -: COORD_W]   = dest_y_q;
        header_flit[DATA_W-2*COORD_W-1 -: COORD_W] = SRC_X;
        header_flit[DATA_W-3*COORD_W-1 -: COORD_W] = SRC_Y;
        header_flit[7:0]                           = len_q;
    end

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        case (state)
            ST_IDLE: begin
                if (req_hs) begin
                    state_nxt = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (slot_free) begin
                    if (len_q == 8'd0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt     = ST_BODY;
                        remaining_nxt = len_q;
                    end
                end
            end
            ST_BODY: begin
                if (load_body) begin
                    remaining_nxt = remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                remaining_nxt = 8'd0;
            end
        endcase
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state     <= ST_IDLE;
            remaining <= 8'd0;
            dest_x_q  <= '0;
            dest_y_q  <= '0;
            len_q     <= 8'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            if (req_hs) begin
                dest_x_q <= req_dest_x;
                dest_y_q <= req_dest_y;
                len_q    <= req_len;
            end
        end
    end

    // Output holding register: only reloads or drains when the slot is free.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
        end else if (load_hdr) begin
            sender_valid     <= 1'b1;
            sender_flit      <= header_flit;
            sender_is_header <= 1'b1;
            sender_is_tail   <= (len_q == 8'd0);
        end else if (load_body) begin
            sender_valid     <= 1'b1;
            sender_flit      <= pl_data;
            sender_is_header <= 1'b0;
            sender_is_tail   <= (remaining == 8'd1);
        end else if (slot_free) begin
            sender_valid <= 1'b0;
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            sent_pkt_cnt <= 8'd0;
        end else if (tail_hs) begin
            sent_pkt_cnt <= sent_pkt_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_noc_packet_injector.sv
// Directed bench for noc_packet_injector: one task per scenario, each with its own
// inline checks against hand-computed flits, flags, cycle positions and counts.
module tb_noc_packet_injector;

    logic        noc_clk = 1'b0;
    logic        noc_rst_n = 1'b0;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_dest_x;
    logic [3:0]  req_dest_y;
    logic [7:0]  req_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;
    logic        sender_valid;
    logic        sender_ready;
    logic [31:0] sender_flit;
    logic        sender_is_header;
    logic        sender_is_tail;
    logic [7:0]  sent_pkt_cnt;

    always #5 noc_clk = ~noc_clk;

    noc_packet_injector #(
        .DATA_W (32),
        .COORD_W(4),
        .X_ID   (0),
        .Y_ID   (0)
    ) dut (
        .noc_clk         (noc_clk),
        .noc_rst_n       (noc_rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_dest_x      (req_dest_x),
        .req_dest_y      (req_dest_y),
        .req_len         (req_len),
        .pl_valid        (pl_valid),
        .pl_ready        (pl_ready),
        .pl_data         (pl_data),
        .sender_valid    (sender_valid),
        .sender_ready    (sender_ready),
        .sender_flit     (sender_flit),
        .sender_is_header(sender_is_header),
        .sender_is_tail  (sender_is_tail),
        .sent_pkt_cnt    (sent_pkt_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_req = 0;
    int pl_rdy_cnt = 0;

    logic [31:0] pl_q[$];
    logic        bubble_en = 1'b0;
    logic        pl_took = 1'b0;

    logic [31:0] mon_flit[$];
    logic        mon_hdr[$];
    logic        mon_tail[$];
    int          mon_cyc[$];

    always @(posedge noc_clk) cyc <= cyc + 1;

    // Record every accepted flit; inputs are stable here since they change just after posedge.
    always @(negedge noc_clk) begin
        pl_took = pl_valid && pl_ready;
        if (pl_ready) pl_rdy_cnt++;
        if (sender_valid && sender_ready) begin
            mon_flit.push_back(sender_flit);
            mon_hdr.push_back(sender_is_header);
            mon_tail.push_back(sender_is_tail);
            mon_cyc.push_back(cyc);
        end
    end

    // Payload source: presents the queue head, optionally idling one cycle after each take.
    initial begin
        pl_valid = 1'b0;
        pl_data  = '0;
        forever begin
            @(posedge noc_clk);
            #2;
            if (pl_took && pl_q.size() > 0) void'(pl_q.pop_front());
            if (pl_q.size() > 0 && !(bubble_en && pl_took)) begin
                pl_valid = 1'b1;
                pl_data  = pl_q[0];
            end else begin
                pl_valid = 1'b0;
                pl_data  = '0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge noc_clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_flit.delete();
        mon_hdr.delete();
        mon_tail.delete();
        mon_cyc.delete();
    endtask

    // Called just after a posedge; returns just after the accepting edge.
    task automatic send_req(input logic [3:0] dx, input logic [3:0] dy, input logic [7:0] ln);
        int n = 0;
        req_valid  = 1'b1;
        req_dest_x = dx;
        req_dest_y = dy;
        req_len    = ln;
        @(negedge noc_clk);
        while (!req_ready && n < 50) begin
            @(negedge noc_clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL req_accept: req_ready=%0b after %0d cycles, required 1", req_ready, n);
        end
        t_req = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_flits(input int n, input int max_cyc, input string nm);
        int k = 0;
        while (mon_flit.size() < n && k < max_cyc) begin
            tick();
            k++;
        end
        if (mon_flit.size() < n) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d flits, required %0d", nm, mon_flit.size(), n);
        end
    endtask

    task automatic test_reset();
        noc_rst_n    = 1'b0;
        req_valid    = 1'b0;
        req_dest_x   = '0;
        req_dest_y   = '0;
        req_len      = '0;
        sender_ready = 1'b0;
        #13;
        total++; if (sender_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", sender_valid); end
        total++; if (sender_flit !== 32'h0) begin bad++; $display("FAIL rst_flit: got %h want 0", sender_flit); end
        total++; if (sender_is_header !== 1'b0 || sender_is_tail !== 1'b0) begin bad++; $display("FAIL rst_flags: got h=%0b t=%0b want 0 0", sender_is_header, sender_is_tail); end
        total++; if (sent_pkt_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt: got %0d want 0", sent_pkt_cnt); end
        total++; if (req_ready !== 1'b1 || pl_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got req=%0b pl=%0b want 1 0", req_ready, pl_ready); end
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        tick();
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_req_ready: got %0b want 1", req_ready); end
    endtask

    task automatic test_single();
        logic [31:0] exp_f[4];
        exp_f = '{32'h1100_0003, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
        sender_ready = 1'b1;
        clear_mon();
        pl_q.push_back(32'hA1);
        pl_q.push_back(32'hA2);
        pl_q.push_back(32'hA3);
        send_req(4'd1, 4'd1, 8'd3);
        wait_flits(4, 100, "single");
        repeat (2) tick();
        total++; if (mon_flit.size() != 4) begin bad++; $display("FAIL single_count: got %0d want 4", mon_flit.size()); end
        for (int i = 0; i < 4; i++) begin
            total++; if (mon_flit[i] !== exp_f[i]) begin bad++; $display("FAIL single_flit%0d: got %h want %h", i, mon_flit[i], exp_f[i]); end
            total++; if (mon_hdr[i] !== (i == 0)) begin bad++; $display("FAIL single_hdr%0d: got %0b want %0b", i, mon_hdr[i], (i == 0)); end
            total++; if (mon_tail[i] !== (i == 3)) begin bad++; $display("FAIL single_tail%0d: got %0b want %0b", i, mon_tail[i], (i == 3)); end
            total++; if (mon_cyc[i] != t_req + 2 + i) begin bad++; $display("FAIL single_cycle%0d: got %0d want %0d", i, mon_cyc[i], t_req + 2 + i); end
        end
        total++; if (sent_pkt_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", sent_pkt_cnt); end
    endtask

    task automatic test_len0();
        int r0;
        r0 = pl_rdy_cnt;
        clear_mon();
        send_req(4'd1, 4'd1, 8'd0);
        wait_flits(1, 50, "len0");
        repeat (3) tick();
        total++; if (mon_flit.size() != 1) begin bad++; $display("FAIL len0_count: got %0d want 1", mon_flit.size()); end
        total++; if (mon_flit[0] !== 32'h1100_0000) begin bad++; $display("FAIL len0_flit: got %h want 11000000", mon_flit[0]); end
        total++; if (mon_hdr[0] !== 1'b1 || mon_tail[0] !== 1'b1) begin bad++; $display("FAIL len0_flags: got h=%0b t=%0b want 1 1", mon_hdr[0], mon_tail[0]); end
        total++; if (mon_cyc[0] != t_req + 2) begin bad++; $display("FAIL len0_cycle: got %0d want %0d", mon_cyc[0], t_req + 2); end
        total++; if (pl_rdy_cnt != r0) begin bad++; $display("FAIL len0_pl_ready: got %0d ready cycles want 0", pl_rdy_cnt - r0); end
        total++; if (sent_pkt_cnt !== 8'd2) begin bad++; $display("FAIL len0_cnt: got %0d want 2", sent_pkt_cnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_f[3];
        exp_f = '{32'h1200_0002, 32'h0000_00B1, 32'h0000_00B2};
        clear_mon();
        sender_ready = 1'b1;
        pl_q.push_back(32'hB1);
        pl_q.push_back(32'hB2);
        send_req(4'd1, 4'd2, 8'd2);
        sender_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge noc_clk);
            total++; if (sender_valid !== 1'b1 || sender_flit !== 32'h1200_0002 || sender_is_header !== 1'b1) begin
                bad++; $display("FAIL bp_hold%0d: got v=%0b flit=%h h=%0b want 1 12000002 1", i, sender_valid, sender_flit, sender_is_header);
            end
            total++; if (pl_ready !== 1'b0) begin bad++; $display("FAIL bp_pl_ready%0d: got %0b want 0", i, pl_ready); end
            tick();
        end
        sender_ready = 1'b1;
        wait_flits(3, 50, "bp");
        repeat (3) tick();
        total++; if (mon_flit.size() != 3) begin bad++; $display("FAIL bp_count: got %0d want 3", mon_flit.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (mon_flit[i] !== exp_f[i]) begin bad++; $display("FAIL bp_flit%0d: got %h want %h", i, mon_flit[i], exp_f[i]); end
            total++; if (mon_tail[i] !== (i == 2)) begin bad++; $display("FAIL bp_tail%0d: got %0b want %0b", i, mon_tail[i], (i == 2)); end
        end
        total++; if (mon_cyc[0] != t_req + 7) begin bad++; $display("FAIL bp_hdr_cycle: got %0d want %0d", mon_cyc[0], t_req + 7); end
        total++; if (pl_q.size() != 0) begin bad++; $display("FAIL bp_payload_left: got %0d want 0", pl_q.size()); end
        total++; if (sent_pkt_cnt !== 8'd3) begin bad++; $display("FAIL bp_cnt: got %0d want 3", sent_pkt_cnt); end
    endtask

    task automatic test_bubbles();
        logic [31:0] exp_f[3];
        exp_f = '{32'h3400_0002, 32'h0000_00C1, 32'h0000_00C2};
        clear_mon();
        sender_ready = 1'b1;
        bubble_en = 1'b1;
        pl_q.push_back(32'hC1);
        pl_q.push_back(32'hC2);
        send_req(4'd3, 4'd4, 8'd2);
        repeat (4) @(negedge noc_clk);
        total++; if (sender_valid !== 1'b0) begin bad++; $display("FAIL bub_gap_valid: got %0b want 0", sender_valid); end
        tick();
        wait_flits(3, 50, "bub");
        repeat (2) tick();
        bubble_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++; if (mon_flit[i] !== exp_f[i]) begin bad++; $display("FAIL bub_flit%0d: got %h want %h", i, mon_flit[i], exp_f[i]); end
            total++; if (mon_tail[i] !== (i == 2)) begin bad++; $display("FAIL bub_tail%0d: got %0b want %0b", i, mon_tail[i], (i == 2)); end
        end
        total++; if (mon_cyc[1] != t_req + 3) begin bad++; $display("FAIL bub_c1_cycle: got %0d want %0d", mon_cyc[1], t_req + 3); end
        total++; if (mon_cyc[2] != t_req + 5) begin bad++; $display("FAIL bub_c2_cycle: got %0d want %0d", mon_cyc[2], t_req + 5); end
        total++; if (sent_pkt_cnt !== 8'd4) begin bad++; $display("FAIL bub_cnt: got %0d want 4", sent_pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        sender_ready = 1'b1;
        for (int i = 0; i < 4; i++) pl_q.push_back(32'hD1 + i);
        send_req(4'd1, 4'd1, 8'd4);
        wait_flits(2, 50, "rstmid");
        #2;
        noc_rst_n = 1'b0;
        pl_q.delete();
        #1;
        total++; if (sender_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %0b want 0", sender_valid); end
        total++; if (sender_flit !== 32'h0 || sender_is_header !== 1'b0 || sender_is_tail !== 1'b0) begin
            bad++; $display("FAIL rstmid_regs: got flit=%h h=%0b t=%0b want 0 0 0", sender_flit, sender_is_header, sender_is_tail);
        end
        total++; if (req_ready !== 1'b1 || pl_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got req=%0b pl=%0b want 1 0", req_ready, pl_ready); end
        total++; if (sent_pkt_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", sent_pkt_cnt); end
        tick();
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        tick();
        total++; if (req_ready !== 1'b1 || sender_valid !== 1'b0) begin bad++; $display("FAIL rstmid_release: got req=%0b v=%0b want 1 0", req_ready, sender_valid); end
        clear_mon();
        pl_q.push_back(32'hE1);
        send_req(4'd2, 4'd2, 8'd1);
        wait_flits(2, 50, "rstmid_new");
        repeat (3) tick();
        total++; if (mon_flit.size() != 2) begin bad++; $display("FAIL rstmid_new_count: got %0d want 2", mon_flit.size()); end
        total++; if (mon_flit[0] !== 32'h2200_0001 || mon_hdr[0] !== 1'b1 || mon_tail[0] !== 1'b0) begin
            bad++; $display("FAIL rstmid_new_hdr: got %h h=%0b t=%0b want 22000001 1 0", mon_flit[0], mon_hdr[0], mon_tail[0]);
        end
        total++; if (mon_flit[1] !== 32'hE1 || mon_hdr[1] !== 1'b0 || mon_tail[1] !== 1'b1) begin
            bad++; $display("FAIL rstmid_new_body: got %h h=%0b t=%0b want e1 0 1", mon_flit[1], mon_hdr[1], mon_tail[1]);
        end
        total++; if (sent_pkt_cnt !== 8'd1) begin bad++; $display("FAIL rstmid_new_cnt: got %0d want 1", sent_pkt_cnt); end
    endtask

    task automatic test_wrap();
        int hdr_n = 0;
        int tail_n = 0;
        int src_err = 0;
        int body_err = 0;
        @(negedge noc_clk);
        noc_rst_n = 1'b0;
        @(negedge noc_clk);
        noc_rst_n = 1'b1;
        tick();
        clear_mon();
        sender_ready = 1'b1;
        for (int i = 0; i < 256; i++) pl_q.push_back(32'hF000_0000 + i);
        for (int i = 0; i < 255; i++) send_req(4'd5, 4'd6, 8'd1);
        wait_flits(510, 200, "wrap255");
        repeat (3) tick();
        total++; if (sent_pkt_cnt !== 8'd255) begin bad++; $display("FAIL wrap_cnt255: got %0d want 255", sent_pkt_cnt); end
        send_req(4'd5, 4'd6, 8'd1);
        wait_flits(512, 50, "wrap256");
        repeat (3) tick();
        total++; if (sent_pkt_cnt !== 8'd0) begin bad++; $display("FAIL wrap_cnt0: got %0d want 0", sent_pkt_cnt); end
        for (int i = 0; i < mon_flit.size(); i++) begin
            if (mon_hdr[i]) begin
                hdr_n++;
                if (mon_flit[i][23:16] !== 8'h00 || mon_flit[i] !== 32'h5600_0001) src_err++;
            end else if (mon_flit[i] !== 32'hF000_0000 + (i / 2) || (i % 2) != 1) begin
                body_err++;
            end
            if (mon_tail[i]) tail_n++;
        end
        total++; if (hdr_n != 256) begin bad++; $display("FAIL wrap_headers: got %0d want 256", hdr_n); end
        total++; if (tail_n != 256) begin bad++; $display("FAIL wrap_tails: got %0d want 256", tail_n); end
        total++; if (src_err != 0) begin bad++; $display("FAIL wrap_header_fields: got %0d bad headers want 0", src_err); end
        total++; if (body_err != 0) begin bad++; $display("FAIL wrap_body: got %0d bad body flits want 0", body_err); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_len0();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
